// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants, update-scheduler state codes and the late-grant window test.
package vga_timing_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE  = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int MIN_LINES = 4;
  localparam int CNT_W     = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;
  localparam logic [1:0] ST_SPENT = 2'd3;

  // True while in vertical blank with at least min_lines lines left before the frame wraps.
  function automatic logic in_update_window(input logic [CNT_W-1:0] v, input int v_act,
                                            input int v_total, input int min_lines);
    int vi;
    vi = int'(v);
    return (vi >= v_act) && ((v_total - vi) >= min_lines);
  endfunction

endpackage

// File: rtl/vga_frame_scheduler_if.sv
// Pixel timing outputs plus the per-frame update-window handshake; master is the scheduler,
// slave is the colour generator / game logic side.
interface vga_frame_scheduler_if;
  import vga_timing_pkg::*;

  logic             pix_en;
  logic             hsync;
  logic             vsync;
  logic             active;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  logic             line_start;
  logic             frame_start;
  logic             upd_req;
  logic             upd_grant;
  logic             upd_done;
  logic             upd_overrun;

  modport master (
    input  pix_en, upd_req, upd_done,
    output hsync, vsync, active, pix_x, pix_y, line_start, frame_start, upd_grant, upd_overrun
  );

  modport slave (
    output pix_en, upd_req, upd_done,
    input  hsync, vsync, active, pix_x, pix_y, line_start, frame_start, upd_grant, upd_overrun
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrap counter with registered sync/active decode and a registered wrap pulse.
// Outputs track the count one clk after en_i is sampled; wrap_o is the combinational cascade enable.
module vga_axis_counter #(
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_WIDTH = 96,
  parameter int W          = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         sync_n_o,
  output logic         active_o,
  output logic         wrap_o,
  output logic         wrap_pulse_o
);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_LIM = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(SYNC_START);
  localparam logic [W-1:0] SYNC_HI = W'(SYNC_START + SYNC_WIDTH - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sync_n_q, sync_n_d;
  logic         active_q, active_d;
  logic         wrap_pulse_q;

  assign wrap_o = en_i && (cnt_q == LAST);

  // Decode the next count so the registered flags line up with the registered count.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
    sync_n_d = !((cnt_d >= SYNC_LO) && (cnt_d <= SYNC_HI));
    active_d = (cnt_d < ACT_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      sync_n_q     <= 1'b1;
      active_q     <= 1'b1;
      wrap_pulse_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sync_n_q     <= sync_n_d;
      active_q     <= active_d;
      wrap_pulse_q <= wrap_o;
    end
  end

  assign cnt_o        = cnt_q;
  assign sync_n_o     = sync_n_q;
  assign active_o     = active_q;
  assign wrap_pulse_o = wrap_pulse_q;

endmodule

// File: rtl/vga_frame_scheduler.sv
// VGA pixel-timing sequencer granting one exclusive vblank update window per frame; all outputs registered.
// Grant opens 1 clk after the window condition; VGA_FRAME_SCHED_OVERRUN_CNT_EN adds a saturating overrun counter.
module vga_frame_scheduler
  import vga_timing_pkg::*;
#(
  parameter int H_ACT           = H_ACTIVE,
  parameter int H_FRONT         = H_FP,
  parameter int H_SYNC_W        = H_SYNC,
  parameter int H_BACK          = H_BP,
  parameter int V_ACT           = V_ACTIVE,
  parameter int V_FRONT         = V_FP,
  parameter int V_SYNC_W        = V_SYNC,
  parameter int V_BACK          = V_BP,
  parameter int MIN_BLANK_LINES = MIN_LINES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vga_frame_scheduler_if.master bus
`ifdef VGA_FRAME_SCHED_OVERRUN_CNT_EN
  ,
  output logic [7:0]            overrun_cnt
`endif
);

  localparam int H_TOT = H_ACT + H_FRONT + H_SYNC_W + H_BACK;
  localparam int V_TOT = V_ACT + V_FRONT + V_SYNC_W + V_BACK;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, f_wrap;
  logic             h_sync_n, v_sync_n, h_act, v_act;
  logic             line_pulse, frame_pulse;

  vga_axis_counter #(
    .TOTAL(H_TOT), .ACTIVE(H_ACT), .SYNC_START(H_ACT + H_FRONT), .SYNC_WIDTH(H_SYNC_W), .W(CNT_W)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .en_i(bus.pix_en), .cnt_o(h_cnt), .sync_n_o(h_sync_n),
    .active_o(h_act), .wrap_o(h_wrap), .wrap_pulse_o(line_pulse)
  );

  // Vertical axis advances only on the horizontal wrap, so its wrap is the frame wrap.
  vga_axis_counter #(
    .TOTAL(V_TOT), .ACTIVE(V_ACT), .SYNC_START(V_ACT + V_FRONT), .SYNC_WIDTH(V_SYNC_W), .W(CNT_W)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .en_i(h_wrap), .cnt_o(v_cnt), .sync_n_o(v_sync_n),
    .active_o(v_act), .wrap_o(f_wrap), .wrap_pulse_o(frame_pulse)
  );

  logic [1:0] state_q, state_d;
  logic       grant_q, overrun_q, overrun_d;

  // SPENT leaves on the registered frame_start so an overrun at the wrap re-arms for the very next vblank.
  always_comb begin
    state_d   = state_q;
    overrun_d = 1'b0;
    case (state_q)
      ST_IDLE:  if (bus.upd_req) state_d = ST_PEND;
      ST_PEND: begin
        if (!bus.upd_req) begin
          state_d = ST_IDLE;
        end else if (in_update_window(v_cnt, V_ACT, V_TOT, MIN_BLANK_LINES)) begin
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (bus.upd_done) begin
          state_d = ST_SPENT;
        end else if (f_wrap) begin
          state_d   = ST_SPENT;
          overrun_d = 1'b1;
        end
      end
      ST_SPENT: if (frame_pulse) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= (state_d == ST_GRANT);
      overrun_q <= overrun_d;
    end
  end

`ifdef VGA_FRAME_SCHED_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt_q <= '0;
    end else if (overrun_d && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign overrun_cnt = ovr_cnt_q;
`endif

  assign bus.hsync       = h_sync_n;
  assign bus.vsync       = v_sync_n;
  assign bus.active      = h_act && v_act;
  assign bus.pix_x       = h_cnt;
  assign bus.pix_y       = v_cnt;
  assign bus.line_start  = line_pulse;
  assign bus.frame_start = frame_pulse;
  assign bus.upd_grant   = grant_q;
  assign bus.upd_overrun = overrun_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Bench: full-size instance checked against a timing table, reduced-size instance against a reference model.
module tb_vga_frame_scheduler;
  import vga_timing_pkg::*;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 12, VF = 2, VS = 2, VB = 5, VT = VA + VF + VS + VB;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  vga_frame_scheduler_if bus_f();
  vga_frame_scheduler_if bus_s();

`ifdef VGA_FRAME_SCHED_OVERRUN_CNT_EN
  logic [7:0] ocnt_f, ocnt_s;
`endif

  vga_frame_scheduler dut_full (
    .clk(clk), .rst_n(rst_n), .bus(bus_f)
`ifdef VGA_FRAME_SCHED_OVERRUN_CNT_EN
    , .overrun_cnt(ocnt_f)
`endif
  );

  vga_frame_scheduler #(
    .H_ACT(HA), .H_FRONT(HF), .H_SYNC_W(HS), .H_BACK(HB),
    .V_ACT(VA), .V_FRONT(VF), .V_SYNC_W(VS), .V_BACK(VB), .MIN_BLANK_LINES(ML)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
`ifdef VGA_FRAME_SCHED_OVERRUN_CNT_EN
    , .overrun_cnt(ocnt_s)
`endif
  );

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting at t=%0t", nm, $time);
  endtask

  // Reference model of the small instance: counters as plain integers, scheduler as request/window/used flags.
  int mh = 0, mv = 0, m_ocnt = 0;
  bit m_ls = 0, m_fs = 0, m_ovr = 0, m_grant = 0, m_waiting = 0, m_used = 0;
  bit hw, fw, fs_seen;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mh = 0; mv = 0; m_ls = 0; m_fs = 0; m_ovr = 0; m_grant = 0;
      m_waiting = 0; m_used = 0; m_ocnt = 0;
    end else begin
      hw      = bus_s.pix_en && (mh == HT - 1);
      fw      = hw && (mv == VT - 1);
      fs_seen = m_fs;
      m_ovr   = 0;
      if (m_grant) begin
        if (bus_s.upd_done) begin
          m_grant = 0; m_used = 1;
        end else if (fw) begin
          m_grant = 0; m_used = 1; m_ovr = 1;
          if (m_ocnt < 255) m_ocnt++;
        end
      end else if (m_used) begin
        if (fs_seen) m_used = 0;
      end else if (m_waiting) begin
        if (!bus_s.upd_req) m_waiting = 0;
        else if (mv >= VA && (VT - mv) >= ML) begin
          m_waiting = 0; m_grant = 1;
        end
      end else if (bus_s.upd_req) begin
        m_waiting = 1;
      end
      if (bus_s.pix_en) begin
        mh = (mh + 1) % HT;
        if (mh == 0) mv = (mv + 1) % VT;
      end
      m_ls = hw;
      m_fs = fw;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_pix_x", 32'(bus_s.pix_x), 32'(mh));
      chk("m_pix_y", 32'(bus_s.pix_y), 32'(mv));
      chk("m_hsync", 32'(bus_s.hsync), 32'(!(mh >= HA + HF && mh < HA + HF + HS)));
      chk("m_vsync", 32'(bus_s.vsync), 32'(!(mv >= VA + VF && mv < VA + VF + VS)));
      chk("m_active", 32'(bus_s.active), 32'(mh < HA && mv < VA));
      chk("m_line_start", 32'(bus_s.line_start), 32'(m_ls));
      chk("m_frame_start", 32'(bus_s.frame_start), 32'(m_fs));
      chk("m_grant", 32'(bus_s.upd_grant), 32'(m_grant));
      chk("m_overrun", 32'(bus_s.upd_overrun), 32'(m_ovr));
`ifdef VGA_FRAME_SCHED_OVERRUN_CNT_EN
      chk("m_ovr_cnt", 32'(ocnt_s), 32'(m_ocnt));
`endif
    end
  end

  task automatic wait_pos(input int y, input int x, input string nm);
    int n = 0;
    while (!(bus_s.pix_y == 10'(y) && bus_s.pix_x == 10'(x))) begin
      @(negedge clk);
      n++;
      if (n > 2 * HT * VT + 10) begin
        tmo(nm);
        return;
      end
    end
  endtask

  task automatic wait_hi(input bit use_ovr, input string nm);
    int n = 0;
    while ((use_ovr ? bus_s.upd_overrun : bus_s.upd_grant) !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 2 * HT * VT + 10) begin
        tmo(nm);
        return;
      end
    end
  endtask

  task automatic done_pulse();
    bus_s.upd_done = 1'b1;
    @(negedge clk);
    bus_s.upd_done = 1'b0;
  endtask

  typedef struct {
    int n; int x; int y; bit hs; bit vs; bit act; bit ls; bit fs;
  } vec_t;
  vec_t tbl [13];

  int cyc, n_grant, n_ovr, first_ls, second_ls, prev_x;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{639,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{640,  640, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{655,  655, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{656,  656, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{751,  751, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{752,  752, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{799,  799, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{800,  0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{801,  1,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1456, 656, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1600, 0,   2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    bus_f.pix_en = 0; bus_f.upd_req = 0; bus_f.upd_done = 0;
    bus_s.pix_en = 0; bus_s.upd_req = 0; bus_s.upd_done = 0;
    repeat (3) @(negedge clk);

    chk("rst_hsync", 32'(bus_s.hsync), 32'(1));
    chk("rst_vsync", 32'(bus_s.vsync), 32'(1));
    chk("rst_active", 32'(bus_s.active), 32'(1));
    chk("rst_pix_x", 32'(bus_s.pix_x), 32'(0));
    chk("rst_pix_y", 32'(bus_s.pix_y), 32'(0));
    chk("rst_line_start", 32'(bus_s.line_start), 32'(0));
    chk("rst_frame_start", 32'(bus_s.frame_start), 32'(0));
    chk("rst_grant", 32'(bus_s.upd_grant), 32'(0));
    chk("rst_overrun", 32'(bus_s.upd_overrun), 32'(0));

    rst_n = 1'b1;
    bus_f.pix_en = 1'b1;
    chk_on = 1'b1;

    // Full-size timing against the table, pix_en held high from reset release.
    cyc = 0;
    for (int i = 0; i < 13; i++) begin
      while (cyc < tbl[i].n) begin
        @(negedge clk);
        cyc++;
      end
      chk("full_pix_x", 32'(bus_f.pix_x), 32'(tbl[i].x));
      chk("full_pix_y", 32'(bus_f.pix_y), 32'(tbl[i].y));
      chk("full_hsync", 32'(bus_f.hsync), 32'(tbl[i].hs));
      chk("full_vsync", 32'(bus_f.vsync), 32'(tbl[i].vs));
      chk("full_active", 32'(bus_f.active), 32'(tbl[i].act));
      chk("full_line_start", 32'(bus_f.line_start), 32'(tbl[i].ls));
      chk("full_frame_start", 32'(bus_f.frame_start), 32'(tbl[i].fs));
    end

    // Request early in the frame: grant at vblank open + 1 clk, done drops it next clk.
    bus_s.pix_en = 1'b1;
    wait_pos(2, 0, "seqA_pos");
    bus_s.upd_req = 1'b1;
    wait_hi(1'b0, "seqA_grant");
    chk("seqA_grant_y", 32'(bus_s.pix_y), 32'(VA));
    chk("seqA_grant_x", 32'(bus_s.pix_x), 32'(1));
    wait_pos(VA + 2, 0, "seqA_done_pos");
    chk("seqA_grant_held", 32'(bus_s.upd_grant), 32'(1));
    done_pulse();
    chk("seqA_grant_drop", 32'(bus_s.upd_grant), 32'(0));
    chk("seqA_no_overrun", 32'(bus_s.upd_overrun), 32'(0));

    // Request held with no done: overrun at frame wrap, then no grant until the next vblank.
    wait_hi(1'b0, "seqB_grant");
    wait_hi(1'b1, "seqB_overrun");
    chk("seqB_ovr_y", 32'(bus_s.pix_y), 32'(0));
    chk("seqB_ovr_x", 32'(bus_s.pix_x), 32'(0));
    chk("seqB_ovr_fs", 32'(bus_s.frame_start), 32'(1));
    chk("seqB_ovr_grant", 32'(bus_s.upd_grant), 32'(0));
    n_grant = 0; n_ovr = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if ((bus_s.pix_y == 10'(VA) && bus_s.pix_x == 10'(1)) || cyc > 2 * HT * VT) break;
      n_grant += int'(bus_s.upd_grant);
      n_ovr += int'(bus_s.upd_overrun);
    end
    chk("seqB_gap_grants", 32'(n_grant), 32'(0));
    chk("seqB_gap_overruns", 32'(n_ovr), 32'(0));
    chk("seqB_regrant", 32'(bus_s.upd_grant), 32'(1));
    done_pulse();
    bus_s.upd_req = 1'b0;

    // Late request with 3 lines left: nothing this frame, grant at next vblank open.
    wait_pos(0, 0, "seqC_frame");
    wait_pos(VT - 3, 0, "seqC_pos");
    bus_s.upd_req = 1'b1;
    n_grant = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if ((bus_s.pix_y == 10'(VA) && bus_s.pix_x == 10'(1)) || cyc > 2 * HT * VT) break;
      n_grant += int'(bus_s.upd_grant);
    end
    chk("seqC_late_no_grant", 32'(n_grant), 32'(0));
    chk("seqC_next_grant", 32'(bus_s.upd_grant), 32'(1));
    done_pulse();
    bus_s.upd_req = 1'b0;

    // Request mid-vblank with room left: grant one clk after pending; done on the wrap clk.
    wait_pos(0, 0, "seqD_frame");
    wait_pos(VA + 3, 5, "seqD_pos");
    bus_s.upd_req = 1'b1;
    @(negedge clk);
    chk("seqD_pend", 32'(bus_s.upd_grant), 32'(0));
    @(negedge clk);
    chk("seqD_grant", 32'(bus_s.upd_grant), 32'(1));
    wait_pos(VT - 1, HT - 1, "seqD_last_pix");
    done_pulse();
    chk("seqD_wrap_no_overrun", 32'(bus_s.upd_overrun), 32'(0));
    chk("seqD_wrap_fs", 32'(bus_s.frame_start), 32'(1));
    chk("seqD_wrap_grant", 32'(bus_s.upd_grant), 32'(0));

    // Asynchronous reset during the window.
    wait_hi(1'b0, "seqE_grant");
    #5 rst_n = 1'b0;
    #1;
    chk("seqE_rst_grant", 32'(bus_s.upd_grant), 32'(0));
    chk("seqE_rst_overrun", 32'(bus_s.upd_overrun), 32'(0));
    chk("seqE_rst_x", 32'(bus_s.pix_x), 32'(0));
    chk("seqE_rst_y", 32'(bus_s.pix_y), 32'(0));
    @(negedge clk);
    @(negedge clk);
    bus_s.upd_req = 1'b0;
    rst_n = 1'b1;

    // pix_en on every other clk: line period doubles, pix_x holds on idle clks.
    first_ls = -1; second_ls = -1; prev_x = 0;
    bus_s.pix_en = 1'b0;
    for (int i = 0; i < 6 * HT; i++) begin
      @(negedge clk);
      if (bus_s.line_start) begin
        if (first_ls < 0) first_ls = i;
        else if (second_ls < 0) second_ls = i;
      end
      if (!bus_s.pix_en && i > 0) chk("seqF_hold_x", 32'(bus_s.pix_x), 32'(prev_x));
      prev_x = int'(bus_s.pix_x);
      bus_s.pix_en = ~bus_s.pix_en;
    end
    chk("seqF_line_period", 32'(second_ls - first_ls), 32'(2 * HT));

    // Randomized traffic against the model.
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      bus_s.pix_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) bus_s.upd_req = ~bus_s.upd_req;
      bus_s.upd_done = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    chk_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
